// File: rtl/vpg_pkg.sv
// Shared definitions for the video pattern generator: pattern mode
// encodings and the colour-bar palette in one-bit-per-channel form.
package vpg_pkg;

    typedef enum logic [2:0] {
        VPG_BARS  = 3'd0,
        VPG_RAMP  = 3'd1,
        VPG_GRID  = 3'd2,
        VPG_SOLID = 3'd3,
        VPG_BOX   = 3'd4
    } vpg_mode_e;

    // Bars left to right, {R,G,B}; each bit expands to a full-scale channel.
    localparam logic [2:0] BAR_RGB [8] = '{
        3'b111,   // white
        3'b110,   // yellow
        3'b011,   // cyan
        3'b010,   // green
        3'b101,   // magenta
        3'b100,   // red
        3'b001,   // blue
        3'b000    // black
    };

endpackage

// File: rtl/vpg_timing.sv
// Raster timing core: pixel/line counters with registered hs/vs/de/sof.
// Counters park at the frame origin while disabled, so a rising enable
// always begins a fresh frame. The raw counters and a few decoded flags
// are exported so a pattern stage can stay aligned with the sync outputs.
module vpg_timing #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP + 1),
    parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt,
    output logic          active,
    output logic          line_last,
    output logic          frame_first,
    output logic          frame_last,
    output logic          hs,
    output logic          vs,
    output logic          de,
    output logic          sof
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic hs_act;
    logic vs_act;

    assign line_last   = (hcnt == H_LAST);
    assign frame_first = (hcnt == '0) && (vcnt == '0);
    assign frame_last  = line_last && (vcnt == V_LAST);
    assign active      = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign hs_act      = (hcnt >= H_SS) && (hcnt < H_SE);
    assign vs_act      = (vcnt >= V_SS) && (vcnt < V_SE);

    // Pixel and line counters; held at the origin while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (!en) begin
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            hcnt <= line_last ? '0 : hcnt + 1'b1;
            if (line_last)
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end
    end

    // Registered sync decode, one stage behind the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs  <= ~HS_POL;
            vs  <= ~VS_POL;
            de  <= 1'b0;
            sof <= 1'b0;
        end else if (!en) begin
            hs  <= ~HS_POL;
            vs  <= ~VS_POL;
            de  <= 1'b0;
            sof <= 1'b0;
        end else begin
            hs  <= hs_act ? HS_POL : ~HS_POL;
            vs  <= vs_act ? VS_POL : ~VS_POL;
            de  <= active;
            sof <= frame_first;
        end
    end

endmodule

// File: rtl/video_pattern_gen.sv
// Parametrised raster timing plus RGB test-pattern generator.
// Mode and solid colour are captured at the frame origin so a frame is
// never mixed; the box animation and frame count advance on the last
// cycle of every frame regardless of the selected pattern.
module video_pattern_gen
    import vpg_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int DATA_W   = 8,
    parameter int GRID     = 32,
    parameter int BOX      = 64
) (
    input  logic                vpg_clk_i,
    input  logic                vpg_rstn_i,
    input  logic                vpg_en_i,
    input  logic [2:0]          vpg_mode_i,
    input  logic [3*DATA_W-1:0] vpg_solid_i,
    output logic                vpg_vs_o,
    output logic                vpg_hs_o,
    output logic                vpg_de_o,
    output logic [3*DATA_W-1:0] vpg_data_o,
    output logic                vpg_sof_o,
    output logic [15:0]         vpg_frame_cnt_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int GW      = $clog2(GRID + 1);
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic [GW-1:0] G_LAST = GW'(GRID - 1);
    localparam logic [HW-1:0] BX_MAX = HW'(H_ACTIVE - BOX);
    localparam logic [VW-1:0] BY_MAX = VW'(V_ACTIVE - BOX);

    function automatic logic [3*DATA_W-1:0] expand(input logic [2:0] c);
        return {{DATA_W{c[2]}}, {DATA_W{c[1]}}, {DATA_W{c[0]}}};
    endfunction

    logic [1:0]          rst_sync;
    logic                rst_n;
    logic [HW-1:0]       hcnt;
    logic [VW-1:0]       vcnt;
    logic                active, line_last, frame_first, frame_last, latch;
    vpg_mode_e           mode_q, mode_eff;
    logic [3*DATA_W-1:0] solid_q, solid_eff, pix, data_q;
    logic [GW-1:0]       gx, gy;
    logic [HW-1:0]       box_x;
    logic [VW-1:0]       box_y;
    logic                dx, dy, in_box;
    logic [2:0]          bar_idx;
    logic [15:0]         frame_cnt;
    int                  xi, yi, bxi, byi;

    // Reset synchroniser: assertion is immediate, release waits two clocks.
    always_ff @(posedge vpg_clk_i or negedge vpg_rstn_i) begin
        if (!vpg_rstn_i) rst_sync <= 2'b00;
        else             rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    vpg_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .HW(HW), .VW(VW)
    ) u_timing (
        .clk(vpg_clk_i), .rst_n(rst_n), .en(vpg_en_i),
        .hcnt(hcnt), .vcnt(vcnt), .active(active), .line_last(line_last),
        .frame_first(frame_first), .frame_last(frame_last),
        .hs(vpg_hs_o), .vs(vpg_vs_o), .de(vpg_de_o), .sof(vpg_sof_o)
    );

    // The origin pixel must already use the newly sampled settings.
    assign latch     = vpg_en_i && frame_first;
    assign mode_eff  = latch ? vpg_mode_e'(vpg_mode_i) : mode_q;
    assign solid_eff = latch ? vpg_solid_i : solid_q;

    // Capture mode and solid colour once per frame at the origin.
    always_ff @(posedge vpg_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= VPG_BARS;
            solid_q <= '0;
        end else if (latch) begin
            mode_q  <= vpg_mode_e'(vpg_mode_i);
            solid_q <= vpg_solid_i;
        end
    end

    // Grid phase counters track hcnt/vcnt modulo GRID without a divider.
    always_ff @(posedge vpg_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            gx <= '0;
            gy <= '0;
        end else if (!vpg_en_i) begin
            gx <= '0;
            gy <= '0;
        end else begin
            gx <= (line_last || gx == G_LAST) ? '0 : gx + 1'b1;
            if (line_last)
                gy <= (frame_last || gy == G_LAST) ? '0 : gy + 1'b1;
        end
    end

    // Box bounce and frame count, stepped on the last cycle of each frame.
    always_ff @(posedge vpg_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            box_x     <= '0;
            box_y     <= '0;
            dx        <= 1'b1;
            dy        <= 1'b1;
            frame_cnt <= '0;
        end else if (vpg_en_i && frame_last) begin
            frame_cnt <= frame_cnt + 16'd1;
            if (dx) begin
                if (box_x == BX_MAX) dx <= 1'b0;
                else                 box_x <= box_x + 1'b1;
            end else begin
                if (box_x == '0) dx <= 1'b1;
                else             box_x <= box_x - 1'b1;
            end
            if (dy) begin
                if (box_y == BY_MAX) dy <= 1'b0;
                else                 box_y <= box_y + 1'b1;
            end else begin
                if (box_y == '0) dy <= 1'b1;
                else             box_y <= box_y - 1'b1;
            end
        end
    end

    assign xi     = int'(hcnt);
    assign yi     = int'(vcnt);
    assign bxi    = int'(box_x);
    assign byi    = int'(box_y);
    assign in_box = (xi >= bxi) && (xi < bxi + BOX) && (yi >= byi) && (yi < byi + BOX);

    // Bar index from constant boundaries; remainder pixels fall in the last bar.
    always_comb begin
        bar_idx = '0;
        for (int k = 1; k < 8; k++)
            if (xi >= k * BAR_W) bar_idx = 3'(k);
    end

    // Pattern select for the current counter position.
    always_comb begin
        pix = '0;
        case (mode_eff)
            VPG_BARS:  pix = expand(BAR_RGB[bar_idx]);
            VPG_RAMP:  pix = {3{xi[DATA_W-1:0]}};
            VPG_GRID:  pix = (gx == '0 || gy == '0) ? '1 : '0;
            VPG_SOLID: pix = solid_eff;
            VPG_BOX:   pix = in_box ? '1 : solid_eff;
            default:   pix = '0;
        endcase
    end

    // Pixel register, blanked outside the active area.
    always_ff @(posedge vpg_clk_i or negedge rst_n) begin
        if (!rst_n) data_q <= '0;
        else        data_q <= (vpg_en_i && active) ? pix : '0;
    end

    assign vpg_data_o      = data_q;
    assign vpg_frame_cnt_o = frame_cnt;

endmodule
